// File: rtl/axi_ram_slave.sv
// axi_ram_slave -- AXI4 responder fronting a word-addressed RAM window.
//
// Serves INCR write (AW/W/B) and read (AR/R) transactions of any length,
// 4-byte beats, one outstanding transaction per direction. The write and
// read engines run independently; a same-word write and fetch on one edge
// returns the old word to the reader.
//
// Ports:
//   CLK, RSTN                   clock (rising edge), async active-low reset
//   S_AXI_AW*                   write address channel (ADDR, LEN, VALID/READY)
//   S_AXI_W*                    write data channel (DATA, STRB, LAST, VALID/READY)
//   S_AXI_B*                    write response channel (RESP, VALID/READY)
//   S_AXI_AR*                   read address channel (ADDR, LEN, VALID/READY)
//   S_AXI_R*                    read data channel (DATA, RESP, LAST, VALID/READY)
//
// Decode: a transaction hits when the start address tag matches BASE_ADDR;
// misses are answered with DECERR and never touch the RAM.

module axi_ram_slave #(
  parameter logic [31:0] BASE_ADDR          = 32'h2000_0000,
  parameter int unsigned MEM_ADDR_WIDTH     = 10,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                            CLK,
  input  logic                            RSTN,
  input  logic [31:0]                     S_AXI_AWADDR,
  input  logic [7:0]                      S_AXI_AWLEN,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WLAST,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [31:0]                     S_AXI_ARADDR,
  input  logic [7:0]                      S_AXI_ARLEN,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RLAST,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int unsigned DEPTH   = 1 << MEM_ADDR_WIDTH;
  localparam int unsigned TAG_LSB = MEM_ADDR_WIDTH + 2;
  localparam int unsigned NBYTES  = C_S_AXI_DATA_WIDTH / 8;

  localparam logic [MEM_ADDR_WIDTH-1:0] IDX_ONE = 1;
  localparam logic [7:0]                CNT_ONE = 8'd1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP}  w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  // Held low through reset and set on the first edge afterwards so that
  // AWREADY/ARREADY stay 0 while RSTN is asserted.
  logic live;

  logic [C_S_AXI_DATA_WIDTH-1:0] mem [DEPTH];

  // Write engine context
  logic [MEM_ADDR_WIDTH-1:0] w_idx;
  logic [7:0]                w_len;
  logic [7:0]                w_cnt;
  logic                      w_hit;
  logic                      w_err;
  logic [1:0]                bresp_q;

  // Read engine context
  logic [MEM_ADDR_WIDTH-1:0]     r_idx;
  logic [7:0]                    r_len;
  logic [7:0]                    r_cnt;
  logic                          r_hit;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;

  logic aw_hit, ar_hit;
  logic aw_fire, w_fire, w_last_beat, w_last_bad;
  logic ar_fire, r_fire, r_last;

  assign aw_hit = (S_AXI_AWADDR[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
  assign ar_hit = (S_AXI_ARADDR[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);

  assign aw_fire     = S_AXI_AWVALID && live && (w_state == W_IDLE);
  assign w_fire      = S_AXI_WVALID && (w_state == W_DATA);
  assign w_last_beat = (w_cnt == w_len);
  assign w_last_bad  = (S_AXI_WLAST != w_last_beat);

  assign ar_fire = S_AXI_ARVALID && live && (r_state == R_IDLE);
  assign r_fire  = S_AXI_RREADY && (r_state == R_DATA);
  assign r_last  = (r_cnt == r_len);

  // Byte-offset bits are ignored by the decode.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      live    <= 1'b0;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
      live    <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_fire) w_next = W_DATA;
      W_DATA:  if (w_fire && w_last_beat) w_next = W_RESP;
      W_RESP:  if (S_AXI_BREADY) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_fire) r_next = R_FETCH;
      R_FETCH: r_next = R_DATA;
      R_DATA:  if (r_fire) r_next = r_last ? R_IDLE : R_FETCH;
      default: r_next = R_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Outputs (decoded from state and registered context only)
  // ---------------------------------------------------------------------
  always_comb begin
    S_AXI_AWREADY = live && (w_state == W_IDLE);
    S_AXI_WREADY  = (w_state == W_DATA);
    S_AXI_BVALID  = (w_state == W_RESP);
    S_AXI_BRESP   = bresp_q;
    S_AXI_ARREADY = live && (r_state == R_IDLE);
    S_AXI_RVALID  = (r_state == R_DATA);
    S_AXI_RDATA   = rdata_q;
    S_AXI_RRESP   = RESP_OKAY;
    S_AXI_RLAST   = 1'b0;
    if (r_state == R_DATA) begin
      S_AXI_RRESP = r_hit ? RESP_OKAY : RESP_DECERR;
      S_AXI_RLAST = r_last;
    end
  end

  // ---------------------------------------------------------------------
  // Write datapath
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      w_idx   <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_hit   <= 1'b0;
      w_err   <= 1'b0;
      bresp_q <= RESP_OKAY;
    end else if (aw_fire) begin
      w_idx <= S_AXI_AWADDR[TAG_LSB-1:2];
      w_len <= S_AXI_AWLEN;
      w_cnt <= '0;
      w_hit <= aw_hit;
      w_err <= 1'b0;
    end else if (w_fire) begin
      w_idx <= w_idx + IDX_ONE;
      w_cnt <= w_cnt + CNT_ONE;
      if (w_last_bad) w_err <= 1'b1;
      // The response folds in this beat's WLAST check, which the error flag
      // only absorbs on the same edge.
      if (w_last_beat) begin
        if (!w_hit)                   bresp_q <= RESP_DECERR;
        else if (w_err || w_last_bad) bresp_q <= RESP_SLVERR;
        else                          bresp_q <= RESP_OKAY;
      end
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge CLK) begin
    if (w_fire && w_hit) begin
      for (int unsigned i = 0; i < NBYTES; i++) begin
        if (S_AXI_WSTRB[i]) mem[w_idx][8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read datapath
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_idx <= '0;
      r_len <= '0;
      r_cnt <= '0;
      r_hit <= 1'b0;
    end else if (ar_fire) begin
      r_idx <= S_AXI_ARADDR[TAG_LSB-1:2];
      r_len <= S_AXI_ARLEN;
      r_cnt <= '0;
      r_hit <= ar_hit;
    end else if (r_fire && !r_last) begin
      r_idx <= r_idx + IDX_ONE;
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  // Non-blocking read of mem gives read-first behaviour against a write
  // to the same word on the same edge.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rdata_q <= '0;
    end else if (r_state == R_FETCH) begin
      rdata_q <= r_hit ? mem[r_idx] : '0;
    end
  end

endmodule

// File: doc/axi_ram_slave.md
Name: axi_ram_slave

Overview:
AXI4 slave (responder) holding a word-addressed RAM. It is the far end of the master interface used by the CPU data/device memory path. It serves the single-beat, 4-byte, INCR-type write (AW/W/B) and read (AR/R) transactions that the core issues, and also accepts INCR bursts. It sits in the SoC as the data/device memory behind the interconnect.

Parameters:
BASE_ADDR, 32'h2000_0000, byte base address of the window; must be aligned to the window size.
MEM_ADDR_WIDTH, 10, log2 of word count (10 gives 1024 words, 4 KiB).
C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.

Ports:
CLK  in  1  clock; all logic on the rising edge.
RSTN  in  1  reset, asynchronous assert, active-low.
S_AXI_AWADDR  in  32  write start byte address.
S_AXI_AWLEN  in  8  write beats minus 1.
S_AXI_AWVALID  in  1  AW valid.
S_AXI_AWREADY  out  1  AW ready.
S_AXI_WDATA  in  32  write data.
S_AXI_WSTRB  in  4  byte enables.
S_AXI_WLAST  in  1  last write beat.
S_AXI_WVALID  in  1  W valid.
S_AXI_WREADY  out  1  W ready.
S_AXI_BRESP  out  2  write response.
S_AXI_BVALID  out  1  B valid.
S_AXI_BREADY  in  1  B ready.
S_AXI_ARADDR  in  32  read start byte address.
S_AXI_ARLEN  in  8  read beats minus 1.
S_AXI_ARVALID  in  1  AR valid.
S_AXI_ARREADY  out  1  AR ready.
S_AXI_RDATA  out  32  read data.
S_AXI_RRESP  out  2  read response.
S_AXI_RLAST  out  1  last read beat.
S_AXI_RVALID  out  1  R valid.
S_AXI_RREADY  in  1  R ready.

Behaviour:
- Address decode:
  - Hit iff ADDR[31:MEM_ADDR_WIDTH+2] == BASE_ADDR[31:MEM_ADDR_WIDTH+2], evaluated on the start address only.
  - Word index = ADDR[MEM_ADDR_WIDTH+1:2]; ADDR[1:0] ignored.
  - Within a burst the index increments by 1 per beat and wraps modulo 2^MEM_ADDR_WIDTH.
- Reset (RSTN=0): all READY/VALID = 0, BRESP = RRESP = 2'b00, RDATA = 0, RLAST = 0, both FSMs return to idle, beat counters = 0.
  - RAM contents are not reset. Beats already written before reset are retained.
  - After RSTN deasserts: AWREADY = ARREADY = 1 on the first clock edge.
- Write FSM (W_IDLE, W_DATA, W_RESP):
  - W_IDLE: AWREADY = 1, WREADY = 0. On AWVALID: latch index, AWLEN and hit; clear the beat counter and error flag; go to W_DATA.
  - W_DATA: AWREADY = 0, WREADY = 1, one beat per cycle.
  - On each WVALID&WREADY beat, if hit: write byte lanes per WSTRB (lane i = WDATA[8i+7:8i]). Then index +1, counter +1.
  - The burst ends on the beat where counter == AWLEN. If WLAST disagrees with that on any beat, set the error flag.
  - At burst end go to W_RESP with BVALID = 1 the next cycle. BRESP = 2'b11 (DECERR) on a miss, else 2'b10 (SLVERR) if the error flag is set, else 2'b00.
  - W_RESP: BVALID held until BREADY, then W_IDLE. AWREADY is 0 throughout W_RESP.
  - Single-beat latency with BREADY = 1: AW handshake at cycle n, W handshake at n+1, BVALID at n+2.
- Read FSM (R_IDLE, R_FETCH, R_DATA):
  - R_IDLE: ARREADY = 1. On ARVALID: latch index, ARLEN and hit; go to R_FETCH.
  - R_FETCH (1 cycle): synchronous RAM read into the RDATA register; RDATA = 0 on a miss. Then R_DATA.
  - R_DATA: RVALID = 1. RRESP = 2'b11 on a miss, else 2'b00. RLAST = (counter == ARLEN).
  - RDATA, RRESP and RLAST are stable while RVALID = 1 and RREADY = 0.
  - On an RREADY handshake: if RLAST, go to R_IDLE (RVALID = 0 next cycle); else index +1, counter +1, go to R_FETCH.
  - Throughput is one beat per 2 cycles. Single-beat latency: AR handshake at cycle n, RVALID at n+2.
- Concurrency:
  - The write and read FSMs are independent and may be active at the same time.
  - When a write and a fetch hit the same word on the same edge, the read returns the old data (read-first).
- Reset asserted mid-burst: outputs go to reset values immediately (asynchronously). No B or R response is produced for the abandoned transaction.

Test Plan:
- Single write: addr 0x2000_0010, data 0xDEADBEEF, WSTRB 4'hF, BREADY = 1 -> BVALID at n+2, BRESP 00. Read of the same address -> RDATA 0xDEADBEEF, RRESP 00, RLAST 1 at n+2.
- Byte strobes: write 0xFFFFFFFF strobe F, then 0x11223344 strobe 4'b0101 to 0x2000_0020 -> read returns 0xFF22FF44.
- Bursts: 4-beat write (AWLEN 3) at 0x2000_0FF8, data 1,2,3,4 -> words 0x3FE, 0x3FF, 0x000, 0x001 hold 1..4. 4-beat read with RREADY toggling 1,0,1,... -> 1,2,3,4 in order, RLAST only on beat 4, data stable while stalled.
- Decode miss: write to 0x3000_0000 -> BRESP 11, RAM unchanged. Read -> RRESP 11, RDATA 0. Single-beat write with WLAST 0 -> BRESP 10.
- Backpressure: BREADY low for 5 cycles -> BVALID and BRESP held, AWREADY 0; BREADY high -> AWREADY 1 the cycle after the B handshake. Concurrently, a read completes normally.
- Reset mid-burst: RSTN low during beat 2 of a 4-beat read -> RVALID 0 without waiting for a clock edge. After release, ARREADY = AWREADY = 1 and the next single read returns correct data.
